afe2256_spi_multi_init: RTL and testbench

AFE2256_SPI_MULTI_INIT -- requirements
Module: afe2256_spi_multi_init

---
 rtl/afe2256_spi_multi_init.sv | 123 ++++++++++++
 tb/tb_afe2256_spi_multi_init.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/afe2256_spi_multi_init.sv
// afe2256_spi_multi_init: table-driven SPI register init for a bank of AFE2256 ROICs,
// broadcast or per-device, with optional REG_READ readback compare.
module afe2256_spi_multi_init #(
  parameter int NUM_ROIC    = 2,
  parameter int CLK_DIV     = 10,
  parameter int CLKS_PER_US = 100,
  parameter int MAX_ENTRIES = 16,
  localparam int IDX_W      = $clog2(MAX_ENTRIES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                seq_mode,
  input  logic                verify_en,
  input  logic [IDX_W:0]      table_len,
  output logic [IDX_W-1:0]    tbl_idx,
  input  logic [7:0]          tbl_addr,
  input  logic [15:0]         tbl_data,
  input  logic [15:0]         tbl_delay_us,
  output logic                spi_sclk,
  output logic                spi_mosi,
  output logic [NUM_ROIC-1:0] spi_cs_n,
  input  logic [NUM_ROIC-1:0] spi_miso,
  output logic                busy,
  output logic                done,
  output logic [NUM_ROIC-1:0] err_mask
);
  typedef enum logic [2:0] {IDLE, FETCH, CS_SETUP, SHIFT, CS_HOLD, GAP, DELAY, DONE} state_t;
  localparam logic [31:0] HALF = 32'(CLK_DIV / 2);
  localparam logic [31:0] DIV  = 32'(CLK_DIV);
  state_t state, state_d;
  logic [31:0] cnt, limit, dly;
  logic [4:0] bit_cnt;
  logic [1:0] fnum;
  logic [2:0] dev;
  logic [IDX_W:0] idx, len_q;
  logic mode_q, ver_q, last, verify, more_frames, more_devs;
  logic [15:0] rd [NUM_ROIC];
  logic [NUM_ROIC-1:0] err, sel, mism;
  logic [23:0] frame_word;
  assign dly         = 32'(tbl_delay_us) * 32'(CLKS_PER_US);
  assign verify      = ver_q && tbl_addr != 8'h00 && tbl_addr != 8'h30;
  assign more_frames = verify && fnum != 2'd3;
  assign more_devs   = mode_q && dev != 3'(NUM_ROIC - 1);
  assign limit       = state == DELAY ? dly : (state == SHIFT || state == GAP) ? DIV : HALF;
  assign last        = cnt == limit - 32'd1;
  assign sel         = mode_q ? NUM_ROIC'(1) << dev : '1;
  // frames 1..3 are the readback trio: REG_READ on, read of tbl_addr, REG_READ off
  assign frame_word  = fnum == 2'd0 ? {tbl_addr, tbl_data} :
                       fnum == 2'd1 ? 24'h000002 :
                       fnum == 2'd2 ? {tbl_addr, 16'h0000} : 24'h000000;
  assign spi_mosi    = state == SHIFT && frame_word[5'd23 - bit_cnt];
  assign spi_sclk    = state == SHIFT && cnt >= HALF;
  assign spi_cs_n    = (state == CS_SETUP || state == SHIFT || state == CS_HOLD) ? ~sel : '1;
  assign busy        = state != IDLE;
  assign done        = state == DONE;
  assign err_mask    = err;
  assign tbl_idx     = idx[IDX_W-1:0];

  always_comb begin
    mism = '0;
    for (int i = 0; i < NUM_ROIC; i++) mism[i] = rd[i] != tbl_data;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:     state_d = start ? FETCH : IDLE;
      FETCH:    state_d = idx >= len_q ? DONE : CS_SETUP;
      CS_SETUP: state_d = last ? SHIFT : CS_SETUP;
      SHIFT:    state_d = (last && bit_cnt == 5'd23) ? CS_HOLD : SHIFT;
      CS_HOLD:  state_d = last ? GAP : CS_HOLD;
      GAP:      state_d = !last ? GAP : (more_frames || more_devs) ? CS_SETUP :
                          dly != 32'd0 ? DELAY : FETCH;
      DELAY:    state_d = last ? FETCH : DELAY;
      DONE:     state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      bit_cnt <= '0;
      fnum <= '0;
      dev <= '0;
      idx <= '0;
      len_q <= '0;
      mode_q <= 1'b0;
      ver_q <= 1'b0;
      err <= '0;
      for (int i = 0; i < NUM_ROIC; i++) rd[i] <= '0;
    end else begin
      cnt <= (state_d == state && !last) ? cnt + 32'd1 : '0;
      bit_cnt <= state != SHIFT ? 5'd0 : last ? bit_cnt + 5'd1 : bit_cnt;
      if (state == IDLE && state_d == FETCH) begin
        mode_q <= seq_mode;
        ver_q <= verify_en;
        len_q <= table_len > (IDX_W+1)'(MAX_ENTRIES) ? (IDX_W+1)'(MAX_ENTRIES) : table_len;
        idx <= '0;
        err <= '0;
      end
      if (state == FETCH) begin
        dev <= '0;
        fnum <= '0;
      end
      if (state == GAP && state_d == CS_SETUP) begin
        fnum <= more_frames ? fnum + 2'd1 : 2'd0;
        dev <= more_frames ? dev : dev + 3'd1;
      end
      if (state_d == FETCH && (state == GAP || state == DELAY)) idx <= idx + 1'b1;
      // capture on the system edge that raises SCLK; the last 16 bits are the read data
      if (state == SHIFT && cnt == HALF - 32'd1)
        for (int i = 0; i < NUM_ROIC; i++) rd[i] <= {rd[i][14:0], spi_miso[i]};
      if (state == CS_HOLD && state_d == GAP && verify && fnum == 2'd2) err <= err | (mism & sel);
    end
  end
endmodule

// File: tb/tb_afe2256_spi_multi_init.sv
// tb_afe2256_spi_multi_init: directed bench with a frame-level timeline model checked every cycle
module tb_afe2256_spi_multi_init;
  localparam int DIV = 10, H = 5, CPU = 100;
  logic clk = 0, rst = 1, start = 0, abort = 0, seq_mode = 0, verify_en = 0;
  logic [4:0] table_len = 0;
  logic [3:0] tbl_idx;
  logic [7:0] tbl_addr;
  logic [15:0] tbl_data, tbl_delay_us;
  logic spi_sclk, spi_mosi, busy, done;
  logic [1:0] spi_cs_n, err_mask;
  logic [1:0] spi_miso = 0;
  logic [7:0] tab_a [16];
  logic [15:0] tab_d [16], tab_u [16], rb [2];
  typedef struct packed {logic [1:0] cs; logic sclk, mosi, busy, done; logic [3:0] idx; logic [1:0] err;} exp_t;
  exp_t exp_q [$];
  int cur_idx = 0, checks = 0, errors = 0, cyc = 0, done_cnt = 0, fn = 0, pos [2];
  logic [1:0] exp_err = 0, fcs = 0;
  logic [23:0] fw = 0;
  logic [23:0] fr_w [$];
  logic [1:0] fr_cs [$];
  int fr_n [$];
  bit run = 0, infr = 0;
  logic prev_sc = 0;

  assign tbl_addr = tab_a[tbl_idx];
  assign tbl_data = tab_d[tbl_idx];
  assign tbl_delay_us = tab_u[tbl_idx];

  afe2256_spi_multi_init dut (.clk(clk), .rst(rst), .start(start), .abort(abort), .seq_mode(seq_mode),
    .verify_en(verify_en), .table_len(table_len), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .tbl_delay_us(tbl_delay_us), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n), .spi_miso(spi_miso), .busy(busy), .done(done), .err_mask(err_mask));

  always #5 clk = ~clk;

  task automatic push(input logic [1:0] cs, input logic sc, input logic mo, input logic dn);
    exp_t e;
    e.cs = cs; e.sclk = sc; e.mosi = mo; e.busy = 1'b1; e.done = dn; e.idx = 4'(cur_idx); e.err = exp_err;
    exp_q.push_back(e);
  endtask

  task automatic frame(input logic [1:0] cs, input logic [23:0] w);
    repeat (H) push(cs, 0, 0, 0);
    for (int b = 23; b >= 0; b--) begin
      repeat (H) push(cs, 0, w[b], 0);
      repeat (H) push(cs, 1, w[b], 0);
    end
    repeat (H) push(cs, 0, 0, 0);
  endtask

  task automatic gap();
    repeat (DIV) push(2'b11, 0, 0, 0);
  endtask

  // expected outputs for every cycle after the start-sampling edge
  task automatic build(input bit seq, input bit ver, input int len);
    logic [1:0] cs;
    exp_err = 0;
    for (int k = 0; k < len; k++) begin
      cur_idx = k;
      push(2'b11, 0, 0, 0);
      for (int d = 0; d < (seq ? 2 : 1); d++) begin
        cs = seq ? ~(2'b01 << d) : 2'b00;
        frame(cs, {tab_a[k], tab_d[k]});
        gap();
        if (ver && tab_a[k] != 8'h00 && tab_a[k] != 8'h30) begin
          frame(cs, 24'h000002);
          gap();
          frame(cs, {tab_a[k], 16'h0000});
          for (int i = 0; i < 2; i++) if (!cs[i] && rb[i] != tab_d[k]) exp_err[i] = 1'b1;
          gap();
          frame(cs, 24'h000000);
          gap();
        end
      end
      repeat (int'(tab_u[k]) * CPU) push(2'b11, 0, 0, 0);
    end
    cur_idx = len;
    push(2'b11, 0, 0, 0);
    push(2'b11, 0, 0, 1);
  endtask

  always @(negedge clk) begin
    exp_t e, g;
    cyc++;
    if (run && !rst) begin
      e = exp_q.size() > 0 ? exp_q.pop_front() : {2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'(cur_idx), exp_err};
      g = {spi_cs_n, spi_sclk, spi_mosi, busy, done, tbl_idx, err_mask};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL cycle %0d: got cs=%b sclk=%b mosi=%b busy=%b done=%b idx=%0d err=%b want cs=%b sclk=%b mosi=%b busy=%b done=%b idx=%0d err=%b",
          cyc, g.cs, g.sclk, g.mosi, g.busy, g.done, g.idx, g.err, e.cs, e.sclk, e.mosi, e.busy, e.done, e.idx, e.err);
      end
    end
  end

  // device emulator (mode 0: MISO moves after SCLK falls) and frame monitor
  always @(negedge clk) begin
    logic [23:0] w;
    for (int i = 0; i < 2; i++) begin
      if (spi_cs_n[i]) pos[i] = 0;
      else if (prev_sc && !spi_sclk) pos[i]++;
      w = {8'h00, rb[i]};
      spi_miso[i] = pos[i] < 24 ? w[23 - pos[i]] : 1'b0;
    end
    if (spi_cs_n != 2'b11) begin
      infr = 1;
      fcs = spi_cs_n;
      if (!prev_sc && spi_sclk) begin
        fw = {fw[22:0], spi_mosi};
        fn++;
      end
    end else if (infr) begin
      fr_w.push_back(fw); fr_cs.push_back(fcs); fr_n.push_back(fn);
      infr = 0; fw = 0; fn = 0;
    end
    prev_sc = spi_sclk;
    if (done) done_cnt++;
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, got, want);
    end
  endtask

  task automatic go(input bit seq, input bit ver, input int len);
    fr_w.delete(); fr_cs.delete(); fr_n.delete(); done_cnt = 0;
    seq_mode = seq; verify_en = ver; table_len = 5'(len); start = 1;
    @(posedge clk); #1 start = 0;
    build(seq, ver, len);
  endtask

  task automatic wait_done(input int max);
    int n;
    for (n = 0; n < max; n++) begin
      @(negedge clk);
      if (done) break;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles", max);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin tab_a[i] = 0; tab_d[i] = 0; tab_u[i] = 0; end
    rb[0] = 0; rb[1] = 0;
    #12;
    chk("rst_cs", 32'(spi_cs_n), 3);
    chk("rst_sclk_mosi", {spi_sclk, spi_mosi}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_err_idx", {err_mask, tbl_idx}, 0);
    @(posedge clk); #1 rst = 0; run = 1;
    repeat (3) @(posedge clk);
    #1;
    tab_a[0] = 8'h5C; tab_d[0] = 16'h4800; tab_u[0] = 0;
    go(0, 0, 1);
    chk("bc_model_len", exp_q.size(), 263);
    wait_done(2000);
    chk("bc_frames", fr_w.size(), 1);
    chk("bc_word", fr_w[0], 24'h5C4800);
    chk("bc_bits", fr_n[0], 24);
    chk("bc_cs", 32'(fr_cs[0]), 0);
    chk("bc_done_cnt", done_cnt, 1);
    tab_a[0] = 8'h00; tab_d[0] = 16'h0001; tab_u[0] = 10;
    go(1, 0, 1);
    chk("seq_model_len", exp_q.size(), 1523);
    repeat (100) @(posedge clk);
    #1 table_len = 0; start = 1;
    @(posedge clk); #1 start = 0;
    wait_done(3000);
    chk("seq_frames", fr_w.size(), 2);
    chk("seq_cs0", 32'(fr_cs[0]), 2);
    chk("seq_cs1", 32'(fr_cs[1]), 1);
    chk("seq_word1", fr_w[1], 24'h000001);
    chk("seq_done_cnt", done_cnt, 1);
    tab_a[0] = 8'h5E; tab_d[0] = 16'h0000; tab_u[0] = 0; rb[0] = 16'h0000; rb[1] = 16'h1000;
    go(0, 1, 1);
    chk("ver_model_len", exp_q.size(), 1043);
    wait_done(3000);
    chk("ver_frames", fr_w.size(), 4);
    chk("ver_w1", fr_w[1], 24'h000002);
    chk("ver_w2", fr_w[2], 24'h5E0000);
    chk("ver_w3", fr_w[3], 24'h000000);
    chk("ver_err", 32'(err_mask), 2);
    go(0, 0, 1);
    repeat (50) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("mid_rst_cs", 32'(spi_cs_n), 3);
    chk("mid_rst_state", {spi_sclk, busy, err_mask, tbl_idx}, 0);
    exp_q.delete(); cur_idx = 0; exp_err = 0;
    @(posedge clk); #1 rst = 0;
    repeat (5) @(posedge clk);
    #1;
    tab_a[0] = 8'h5C; tab_d[0] = 16'h4800;
    go(0, 0, 1);
    repeat (132) @(posedge clk);
    #1;
    chk("abort_pre_cs", 32'(spi_cs_n), 0);
    chk("abort_pre_bits", fn, 13);
    abort = 1;
    @(posedge clk); #1 abort = 0;
    exp_q.delete(); cur_idx = 0; exp_err = 0;
    chk("abort_cs", 32'(spi_cs_n), 3);
    chk("abort_sclk_busy", {spi_sclk, busy}, 0);
    repeat (300) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    go(0, 0, 0);
    chk("zero_model_len", exp_q.size(), 2);
    @(negedge clk);
    chk("zero_done_c1", done, 0);
    @(negedge clk);
    chk("zero_done_c2", done, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("zero_no_cs", fr_w.size(), 0);
    chk("zero_done_cnt", done_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
